// File: rtl/amba_cfg_pkg.sv
// Shared definitions for the configuration bus master: register map, FSM states,
// command record and the address-decode helper.
package amba_cfg_pkg;

    localparam logic [7:0] ADDR_CTRL = 8'h10;
    localparam logic [7:0] ADDR_TX   = 8'h21;
    localparam logic [7:0] ADDR_RX   = 8'h22;
    localparam logic [7:0] ADDR_TP0  = 8'h23;
    localparam logic [7:0] ADDR_TP1  = 8'h24;

    localparam int NUM_BOOT = 5;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2,
        IDLE = 2'd3
    } state_t;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } cfg_cmd_t;

    function automatic logic is_mapped(input logic [7:0] addr);
        return (addr == ADDR_CTRL) || (addr == ADDR_TX) || (addr == ADDR_RX) ||
               (addr == ADDR_TP0)  || (addr == ADDR_TP1);
    endfunction

endpackage

// File: rtl/amba_cfg_fifo.sv
// Small first-word-fall-through command FIFO; the head entry is visible on o_dout
// whenever o_empty is low so the master can decode it in the pop cycle.
module amba_cfg_fifo
    import amba_cfg_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     i_push,
    input  cfg_cmd_t i_din,
    input  logic     i_pop,
    output cfg_cmd_t o_dout,
    output logic     o_full,
    output logic     o_empty
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    cfg_cmd_t      r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == (PW+1)'(FIFO_DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_dout  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Depth is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/amba_cfg_master.sv
// Configuration bus initiator: writes the boot image to the five mapped registers,
// then forwards queued host writes with a bounded wait for bus_ready.
module amba_cfg_master
    import amba_cfg_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter int         TIMEOUT    = 16,
    parameter logic [7:0] BOOT_CTRL  = 8'h00,
    parameter logic [7:0] BOOT_TX    = 8'h00,
    parameter logic [7:0] BOOT_RX    = 8'h00,
    parameter logic [7:0] BOOT_TP0   = 8'h00,
    parameter logic [7:0] BOOT_TP1   = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_cmd_valid,
    output logic       o_cmd_ready,
    input  logic [7:0] i_cmd_addr,
    input  logic [7:0] i_cmd_data,
    output logic       o_bus_valid,
    output logic [7:0] o_bus_addr,
    output logic [7:0] o_bus_data,
    input  logic       i_bus_ready,
    output logic       o_boot_done,
    output logic       o_busy,
    output logic       o_err_timeout,
    output logic       o_err_badaddr,
    output logic [7:0] o_err_addr,
    input  logic       i_err_clr
);

    localparam int             TW        = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]  TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [2:0]     BOOT_LAST = 3'(NUM_BOOT - 1);

    state_t        r_state;
    logic [2:0]    r_boot_idx;
    logic [TW-1:0] r_tmo_cnt;
    logic          r_bus_valid;
    logic [7:0]    r_bus_addr;
    logic [7:0]    r_bus_data;
    logic          r_boot_done;
    logic          r_err_timeout;
    logic          r_err_badaddr;
    logic [7:0]    r_err_addr;

    cfg_cmd_t      w_cmd_in;
    cfg_cmd_t      w_head;
    cfg_cmd_t      w_boot_cmd;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic          w_pop;
    logic          w_done_xfer;

    assign w_cmd_in = '{addr: i_cmd_addr, data: i_cmd_data};
    assign w_pop    = (r_state == IDLE) && !w_fifo_empty;

    amba_cfg_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (i_cmd_valid),
        .i_din   (w_cmd_in),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_comb begin
        w_boot_cmd = '{addr: ADDR_CTRL, data: BOOT_CTRL};
        case (r_boot_idx)
            3'd1:    w_boot_cmd = '{addr: ADDR_TX,  data: BOOT_TX};
            3'd2:    w_boot_cmd = '{addr: ADDR_RX,  data: BOOT_RX};
            3'd3:    w_boot_cmd = '{addr: ADDR_TP0, data: BOOT_TP0};
            3'd4:    w_boot_cmd = '{addr: ADDR_TP1, data: BOOT_TP1};
            default: w_boot_cmd = '{addr: ADDR_CTRL, data: BOOT_CTRL};
        endcase
    end

    // A transfer ends either on the handshake or on the last permitted wait cycle.
    assign w_done_xfer = i_bus_ready || (r_tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= BOOT;
            r_boot_idx    <= '0;
            r_tmo_cnt     <= '0;
            r_bus_valid   <= 1'b0;
            r_bus_addr    <= '0;
            r_bus_data    <= '0;
            r_boot_done   <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_badaddr <= 1'b0;
            r_err_addr    <= '0;
        end else begin
            // Clear first so that an error raised below in the same cycle wins.
            if (i_err_clr) begin
                r_err_timeout <= 1'b0;
                r_err_badaddr <= 1'b0;
            end
            case (r_state)
                BOOT: begin
                    r_bus_addr  <= w_boot_cmd.addr;
                    r_bus_data  <= w_boot_cmd.data;
                    r_bus_valid <= 1'b1;
                    r_tmo_cnt   <= '0;
                    r_state     <= XFER;
                end
                XFER: begin
                    if (w_done_xfer) begin
                        r_bus_valid <= 1'b0;
                        r_state     <= GAP;
                        if (!i_bus_ready) begin
                            r_err_timeout <= 1'b1;
                            r_err_addr    <= r_bus_addr;
                        end
                        if (!r_boot_done) begin
                            r_boot_idx <= r_boot_idx + 1'b1;
                            if (r_boot_idx == BOOT_LAST) begin
                                r_boot_done <= 1'b1;
                            end
                        end
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                GAP: begin
                    // The gap cycle doubles as the load cycle for the next boot entry.
                    if (!r_boot_done) begin
                        r_bus_addr  <= w_boot_cmd.addr;
                        r_bus_data  <= w_boot_cmd.data;
                        r_bus_valid <= 1'b1;
                        r_tmo_cnt   <= '0;
                        r_state     <= XFER;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                IDLE: begin
                    if (!w_fifo_empty) begin
                        if (is_mapped(w_head.addr)) begin
                            r_bus_addr  <= w_head.addr;
                            r_bus_data  <= w_head.data;
                            r_bus_valid <= 1'b1;
                            r_tmo_cnt   <= '0;
                            r_state     <= XFER;
                        end else begin
                            r_err_badaddr <= 1'b1;
                            r_err_addr    <= w_head.addr;
                        end
                    end
                end
                default: begin
                    r_bus_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign o_cmd_ready   = !w_fifo_full;
    assign o_bus_valid   = r_bus_valid;
    assign o_bus_addr    = r_bus_addr;
    assign o_bus_data    = r_bus_data;
    assign o_boot_done   = r_boot_done;
    assign o_busy        = (r_state != IDLE) || !w_fifo_empty || !r_boot_done;
    assign o_err_timeout = r_err_timeout;
    assign o_err_badaddr = r_err_badaddr;
    assign o_err_addr    = r_err_addr;

endmodule

// File: tb/tb_amba_cfg_master.sv
// Directed bench for amba_cfg_master: boot image, delayed handshakes, timeout,
// bad address, FIFO full during boot and reset mid-transfer.
module tb_amba_cfg_master;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       bus_valid;
    logic [7:0] bus_addr;
    logic [7:0] bus_data;
    logic       bus_ready;
    logic       boot_done;
    logic       busy;
    logic       err_timeout;
    logic       err_badaddr;
    logic [7:0] err_addr;
    logic       err_clr;

    int n_pass;
    int n_total;

    logic [7:0] boot_addr [5];
    logic [7:0] boot_val  [5];
    logic [7:0] q_addr    [5];
    logic [7:0] q_data    [5];

    amba_cfg_master #(
        .FIFO_DEPTH (4),
        .TIMEOUT    (16),
        .BOOT_CTRL  (8'h05),
        .BOOT_TX    (8'hA1),
        .BOOT_RX    (8'hB2),
        .BOOT_TP0   (8'hC3),
        .BOOT_TP1   (8'hD4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_cmd_valid   (cmd_valid),
        .o_cmd_ready   (cmd_ready),
        .i_cmd_addr    (cmd_addr),
        .i_cmd_data    (cmd_data),
        .o_bus_valid   (bus_valid),
        .o_bus_addr    (bus_addr),
        .o_bus_data    (bus_data),
        .i_bus_ready   (bus_ready),
        .o_boot_done   (boot_done),
        .o_busy        (busy),
        .o_err_timeout (err_timeout),
        .o_err_badaddr (err_badaddr),
        .o_err_addr    (err_addr),
        .i_err_clr     (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int budget, output int n);
        n = 0;
        while (!bus_valid && n < budget) begin
            tick();
            n++;
        end
    endtask

    // Holds ready low for 'delay' valid cycles, then completes the handshake.
    task automatic hold_xfer(input string tag, input logic [7:0] a, input logic [7:0] d, input int delay);
        for (int i = 0; i < delay; i++) begin
            check({tag, "_valid_wait"}, bus_valid, 1'b1);
            check({tag, "_addr_wait"}, bus_addr, a);
            check({tag, "_data_wait"}, bus_data, d);
            tick();
        end
        bus_ready = 1'b1;
        check({tag, "_valid"}, bus_valid, 1'b1);
        check({tag, "_addr"}, bus_addr, a);
        check({tag, "_data"}, bus_data, d);
        tick();
        check({tag, "_drop"}, bus_valid, 1'b0);
        $display("xfer %s addr=%02h data=%02h held=%0d", tag, a, d, delay + 1);
    endtask

    task automatic run_boot(input string tag);
        int n;
        for (int k = 0; k < 5; k++) begin
            wait_valid(8, n);
            check($sformatf("%s_gap%0d", tag, k), n, 1);
            hold_xfer($sformatf("%s_e%0d", tag, k), boot_addr[k], boot_val[k], 0);
        end
        check({tag, "_boot_done"}, boot_done, 1'b1);
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0;
        err_clr   = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_valid_async", bus_valid, 1'b0);
        tick();
        tick();
        check("rst_bus_addr", bus_addr, 8'h00);
        check("rst_bus_data", bus_data, 8'h00);
        check("rst_boot_done", boot_done, 1'b0);
        check("rst_err_to", err_timeout, 1'b0);
        check("rst_err_bad", err_badaddr, 1'b0);
        check("rst_err_addr", err_addr, 8'h00);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_busy", busy, 1'b1);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        n_pass  = 0;
        n_total = 0;
        boot_addr = '{8'h10, 8'h21, 8'h22, 8'h23, 8'h24};
        boot_val  = '{8'h05, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = 8'h00;
        cmd_data  = 8'h00;
        bus_ready = 1'b1;
        err_clr   = 1'b0;

        // Boot with ready tied high.
        tick();
        do_reset();
        run_boot("boot");
        tick();
        check("boot_idle_busy", busy, 1'b0);

        // Two host writes, ready delayed two cycles each.
        bus_ready = 1'b0;
        cmd_valid = 1'b1; cmd_addr = 8'h21; cmd_data = 8'hA5;
        tick();
        cmd_addr = 8'h24; cmd_data = 8'h3C;
        tick();
        cmd_valid = 1'b0;
        check("host_latency", bus_valid, 1'b1);
        hold_xfer("host0", 8'h21, 8'hA5, 2);
        bus_ready = 1'b0;
        check("host_busy_mid", busy, 1'b1);
        wait_valid(8, n);
        hold_xfer("host1", 8'h24, 8'h3C, 2);
        bus_ready = 1'b0;
        tick();
        check("host_busy_fall", busy, 1'b0);

        // Timeout on a write to 0x22.
        cmd_valid = 1'b1; cmd_addr = 8'h22; cmd_data = 8'h77;
        tick();
        cmd_valid = 1'b0;
        tick();
        check("tmo_addr", bus_addr, 8'h22);
        n = 0;
        while (bus_valid && n < 40) begin
            n++;
            tick();
        end
        check("tmo_valid_cycles", n, 16);
        check("tmo_flag", err_timeout, 1'b1);
        check("tmo_err_addr", err_addr, 8'h22);
        check("tmo_bad_flag", err_badaddr, 1'b0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("tmo_clr_flag", err_timeout, 1'b0);
        check("tmo_clr_addr_hold", err_addr, 8'h22);
        $display("timeout addr=22 valid_cycles=%0d", n);

        // Unmapped address dropped; err_clr in the same cycle loses to the new error.
        cmd_valid = 1'b1; cmd_addr = 8'h55; cmd_data = 8'h01;
        tick();
        cmd_addr = 8'h10; cmd_data = 8'h0F; err_clr = 1'b1;
        tick();
        cmd_valid = 1'b0; err_clr = 1'b0;
        check("bad_no_valid", bus_valid, 1'b0);
        check("bad_flag", err_badaddr, 1'b1);
        check("bad_err_addr", err_addr, 8'h55);
        tick();
        hold_xfer("bad_next", 8'h10, 8'h0F, 0);
        check("bad_flag_sticky", err_badaddr, 1'b1);
        check("bad_tmo_clear", err_timeout, 1'b0);

        // Reset while a transfer is pending and a command is queued.
        bus_ready = 1'b0;
        cmd_valid = 1'b1; cmd_addr = 8'h23; cmd_data = 8'h44;
        tick();
        cmd_addr = 8'h24; cmd_data = 8'h99;
        tick();
        cmd_valid = 1'b0;
        check("mid_valid", bus_valid, 1'b1);
        check("mid_addr", bus_addr, 8'h23);
        bus_ready = 1'b1;
        do_reset();
        run_boot("reboot");
        tick();
        check("reboot_fifo_empty_busy", busy, 1'b0);
        tick(); tick(); tick();
        check("reboot_no_stale_xfer", bus_valid, 1'b0);

        // Fill the FIFO during boot; the fifth command waits for the first pop.
        q_addr = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h10};
        q_data = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cmd_valid = 1'b1; cmd_addr = q_addr[i]; cmd_data = q_data[i];
            check($sformatf("full_ready%0d", i), cmd_ready, 1'b1);
            tick();
        end
        cmd_addr = q_addr[4]; cmd_data = q_data[4];
        check("full_ready_low", cmd_ready, 1'b0);
        tick();
        tick();
        check("full_ready_held", cmd_ready, 1'b0);
        check("full_boot_pending", boot_done, 1'b0);
        n = 0;
        while (!cmd_ready && n < 30) begin
            tick();
            n++;
        end
        check("full_ready_return", cmd_ready, 1'b1);
        check("full_boot_done", boot_done, 1'b1);
        check("full_q0_valid", bus_valid, 1'b1);
        check("full_q0_addr", bus_addr, q_addr[0]);
        check("full_q0_data", bus_data, q_data[0]);
        tick();
        cmd_valid = 1'b0;
        $display("xfer full_q0 addr=%02h data=%02h", q_addr[0], q_data[0]);
        for (int i = 1; i < 5; i++) begin
            wait_valid(8, n);
            hold_xfer($sformatf("full_q%0d", i), q_addr[i], q_data[i], 0);
        end
        tick();
        check("full_drained_busy", busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/amba_cfg_master.md
Name: amba_cfg_master

Overview:
- Initiator side of the valid/ready register-write bus used by the peripheral configuration slave. Address map: 0x10 control, 0x21 tx_slot, 0x22 rx_slot, 0x23 tpuint_byte0, 0x24 tpuint_byte1.
- After reset, autonomously writes a boot configuration to all five registers.
- Then forwards host write commands from a small command FIFO onto the bus, with timeout and address checking.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries; power of two, ≥2.
- TIMEOUT, 16, max cycles bus_valid may wait for bus_ready before abort; ≥1.
- BOOT_CTRL, 8'h00, boot value written to 0x10.
- BOOT_TX, 8'h00, boot value written to 0x21.
- BOOT_RX, 8'h00, boot value written to 0x22.
- BOOT_TP0, 8'h00, boot value written to 0x23.
- BOOT_TP1, 8'h00, boot value written to 0x24.

Ports:
- clk  in  1  single clock, all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  host command present.
- cmd_ready  out  1  FIFO can accept (= !full).
- cmd_addr  in  8  target register address.
- cmd_data  in  8  write data.
- bus_valid  out  1  bus write request.
- bus_addr  out  8  bus address.
- bus_data  out  8  bus write data.
- bus_ready  in  1  slave acceptance.
- boot_done  out  1  high once the boot sequence finishes; stays high until reset.
- busy  out  1  transfer in progress, or FIFO non-empty, or boot not done.
- err_timeout  out  1  sticky; a transfer was aborted.
- err_badaddr  out  1  sticky; a command with an unmapped address was dropped.
- err_addr  out  8  address of the most recent errored command.
- err_clr  in  1  clears both sticky flags; err_addr holds its value.

Behaviour:
- Reset (async assert, sync release) values:
  - bus_valid=0, bus_addr=0, bus_data=0, boot_done=0.
  - err_*=0, FIFO empty, state=BOOT, boot index=0, timeout counter=0.
- States:
  - BOOT: load the boot entry at the index, go to XFER.
  - XFER: drive bus_valid.
  - GAP: one idle cycle.
  - IDLE.
- Handshake:
  - While in XFER, bus_valid=1 and bus_addr/bus_data are stable.
  - The transfer completes at the first posedge with bus_valid&bus_ready.
  - bus_valid drops the following cycle (GAP); at least one idle cycle between transfers.
  - bus_ready is ignored while bus_valid=0.
- Timeout:
  - Counter increments each XFER cycle with bus_ready=0.
  - When TIMEOUT cycles elapse without ready: abort, set err_timeout, capture err_addr=bus_addr, go to GAP.
- Boot:
  - Fixed order 0x10, 0x21, 0x22, 0x23, 0x24 using the BOOT_* values.
  - A timeout on a boot entry still advances to the next entry.
  - boot_done rises in the GAP after the fifth entry.
- IDLE:
  - If FIFO non-empty, pop the head.
  - Mapped address: load bus regs, go to XFER. Latency from a push into an empty FIFO in IDLE to bus_valid=1 is 2 cycles (push cycle, pop cycle).
  - Unmapped address: set err_badaddr, err_addr=cmd address, no bus activity, remain IDLE.
- FIFO:
  - Push on cmd_valid&cmd_ready; this is accepted during BOOT too.
  - Commands drain in order only after boot_done.
  - Full: cmd_ready=0, no overwrite.
  - Simultaneous push and pop when full is impossible because cmd_ready is low.
  - Simultaneous push and pop at other depths keeps the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- 0x10: full byte is forwarded; the slave uses only [3:0].
- Errors: err_clr in the same cycle as a new error leaves the error set (set wins).
- Reset mid-transfer: bus_valid drops immediately; FIFO contents are discarded; boot reruns.

Decomposition:
- Shared package amba_cfg_pkg:
  - Address constants ADDR_CTRL=8'h10, ADDR_TX=8'h21, ADDR_RX=8'h22, ADDR_TP0=8'h23, ADDR_TP1=8'h24.
  - Enum state_t {BOOT, XFER, GAP, IDLE}.
  - Struct cfg_cmd_t {addr, data}.
  - Function is_mapped(addr).
- One sub-module: amba_cfg_fifo, a synchronous FIFO of cfg_cmd_t with FIFO_DEPTH, async active-low reset, full/empty outputs.

Test Plan:
- Boot, slave ready tied 1: release rst_n → five transfers 0x10, 0x21, 0x22, 0x23, 0x24 with BOOT_* data, each valid for 1 cycle, 1-cycle gap; boot_done=1 after the fifth.
- Host writes (0x21,0xA5) then (0x24,0x3C) with slave ready delayed 2 cycles → each bus_valid held 3 cycles with stable addr/data; order preserved; busy falls after the second.
- Timeout: after boot, bus_ready held 0 and a write to 0x22 → bus_valid high exactly TIMEOUT=16 cycles, then err_timeout=1, err_addr=0x22; err_clr → flag 0.
- Bad address: cmd (0x55,0x01) → no bus_valid; err_badaddr=1, err_addr=0x55; a following (0x10,0x0F) still issues normally.
- FIFO full: push 5 commands during BOOT → cmd_ready=0 after the fourth accepted; the fifth is held; all drain in order after boot_done.
- Reset mid-transfer: assert rst_n=0 while bus_valid=1 → bus_valid=0 the same cycle, FIFO empty; on release the boot sequence restarts at 0x10.
